// File: rtl/bin_to_bcd_seq_if.sv
// Operand/result handshake bundle for the sequential binary-to-BCD converter.
// The master drives operands and consumes results; the slave is the converter.
interface bin_to_bcd_seq_if #(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3
);
  logic [IN_W-1:0]     bin_i;
  logic                valid_i;
  logic                ready_o;
  logic [4*DIGITS-1:0] bcd_o;
  logic                valid_o;
  logic                ready_i;

  modport master (
    output bin_i, valid_i, ready_i,
    input  ready_o, bcd_o, valid_o
  );

  modport slave (
    input  bin_i, valid_i, ready_i,
    output ready_o, bcd_o, valid_o
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one operand bit per SHIFT cycle, result
// held in a registered output until the downstream consumer takes it.
module bin_to_bcd_seq #(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  bin_to_bcd_seq_if.slave   io
);
  localparam int SCR_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e            state_q, state_d;
  logic [IN_W-1:0]   shreg_q, shreg_d, shreg_shift;
  logic [SCR_W-1:0]  scr_q, scr_d, scr_adj, scr_shift;
  logic [SCR_W-1:0]  bcd_q, bcd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              vld_q, vld_d;

  // Per-digit add-3 correction; 4-bit arithmetic, no carry between digits.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    assign scr_adj[4*g +: 4] = (scr_q[4*g +: 4] >= 4'd5) ? (scr_q[4*g +: 4] + 4'd3)
                                                         : scr_q[4*g +: 4];
  end

  // The shreg MSB falls into the ones-digit LSB as the pair shifts together.
  assign {scr_shift, shreg_shift} = {scr_adj, shreg_q} << 1;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: begin
        if (io.valid_i) begin
          shreg_d = io.bin_i;
          scr_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d = shreg_shift;
        scr_d   = scr_shift;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(IN_W - 1)) begin
          bcd_d   = scr_shift;
          vld_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (io.ready_i) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      shreg_q <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      vld_q   <= vld_d;
    end
  end

  assign io.ready_o = (state_q == IDLE);
  assign io.bcd_o   = bcd_q;
  assign io.valid_o = vld_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed and sweep bench for bin_to_bcd_seq; inputs change and outputs are
// sampled 1ns after each rising edge.
module tb_bin_to_bcd_seq;
  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  bin_to_bcd_seq_if #(.IN_W(8), .DIGITS(3)) io ();

  bin_to_bcd_seq #(.IN_W(8), .DIGITS(3)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .io     (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for ready_o, then presents one operand for one edge.
  task automatic send(input logic [7:0] b);
    for (int i = 0; i < 20 && io.ready_o !== 1'b1; i++) tick();
    io.bin_i   = b;
    io.valid_i = 1'b1;
    tick();
    io.valid_i = 1'b0;
  endtask

  // Counts edges until valid_o rises; gives up after 20.
  task automatic wait_valid(output int k);
    k = 0;
    while (io.valid_o !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
  endtask

  function automatic logic [11:0] dec_ref(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; io.valid_i = 1'b0; io.ready_i = 1'b0; io.bin_i = '0;
    tick(); tick();
    total++; if (io.ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", io.ready_o); end
    total++; if (io.valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", io.valid_o); end
    total++; if (io.bcd_o !== 12'h000) begin bad++; $display("FAIL reset_bcd: got %h want 000", io.bcd_o); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int k;
    send(8'd225);
    total++; if (io.ready_o !== 1'b0) begin bad++; $display("FAIL basic_busy: got %b want 0", io.ready_o); end
    wait_valid(k);
    total++; if (k != 8) begin bad++; $display("FAIL basic_latency: got %0d want 8", k); end
    total++; if (io.bcd_o !== 12'h225) begin bad++; $display("FAIL basic_bcd: got %h want 225", io.bcd_o); end
    io.ready_i = 1'b1;
    tick();
    io.ready_i = 1'b0;
    total++; if (io.valid_o !== 1'b0) begin bad++; $display("FAIL basic_consume: got %b want 0", io.valid_o); end
    total++; if (io.ready_o !== 1'b1) begin bad++; $display("FAIL basic_idle: got %b want 1", io.ready_o); end
  endtask

  task automatic test_bounds();
    int k;
    send(8'd255);
    wait_valid(k);
    total++; if (k != 8) begin bad++; $display("FAIL max_latency: got %0d want 8", k); end
    total++; if (io.bcd_o !== 12'h255) begin bad++; $display("FAIL max_bcd: got %h want 255", io.bcd_o); end
    io.ready_i = 1'b1; tick(); io.ready_i = 1'b0;
    total++; if (io.bcd_o !== 12'h255) begin bad++; $display("FAIL hold_idle: got %h want 255", io.bcd_o); end
    send(8'd0);
    tick();
    total++; if (io.bcd_o !== 12'h255) begin bad++; $display("FAIL hold_shift: got %h want 255", io.bcd_o); end
    wait_valid(k);
    total++; if (k != 7) begin bad++; $display("FAIL zero_latency: got %0d want 7 more", k); end
    total++; if (io.bcd_o !== 12'h000) begin bad++; $display("FAIL zero_bcd: got %h want 000", io.bcd_o); end
    io.ready_i = 1'b1; tick(); io.ready_i = 1'b0;
  endtask

  task automatic test_backpressure();
    int k;
    send(8'd137);
    wait_valid(k);
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (io.valid_o !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d]: got %b want 1", i, io.valid_o); end
      total++; if (io.bcd_o !== 12'h137) begin bad++; $display("FAIL bp_bcd[%0d]: got %h want 137", i, io.bcd_o); end
    end
    io.ready_i = 1'b1; tick(); io.ready_i = 1'b0;
    total++; if (io.valid_o !== 1'b0) begin bad++; $display("FAIL bp_release: got %b want 0", io.valid_o); end
  endtask

  task automatic test_back_to_back();
    int k;
    io.ready_i = 1'b1; io.bin_i = 8'd9; io.valid_i = 1'b1;
    tick();
    io.bin_i = 8'd42;
    wait_valid(k);
    total++; if (k != 8) begin bad++; $display("FAIL b2b_lat1: got %0d want 8", k); end
    total++; if (io.bcd_o !== 12'h009) begin bad++; $display("FAIL b2b_bcd1: got %h want 009", io.bcd_o); end
    tick();
    total++; if (io.ready_o !== 1'b1) begin bad++; $display("FAIL b2b_idle: got %b want 1", io.ready_o); end
    tick();
    io.valid_i = 1'b0;
    total++; if (io.ready_o !== 1'b0) begin bad++; $display("FAIL b2b_accept2: got %b want 0", io.ready_o); end
    wait_valid(k);
    total++; if (k != 8) begin bad++; $display("FAIL b2b_lat2: got %0d want 8", k); end
    total++; if (io.bcd_o !== 12'h042) begin bad++; $display("FAIL b2b_bcd2: got %h want 042", io.bcd_o); end
    tick();
    io.ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    int k;
    send(8'd200);
    tick(); tick(); tick();
    total++; if (io.bcd_o !== 12'h042) begin bad++; $display("FAIL mid_hold: got %h want 042", io.bcd_o); end
    rst_n = 1'b0;
    #1;
    total++; if (io.bcd_o !== 12'h000) begin bad++; $display("FAIL mid_rst_bcd: got %h want 000", io.bcd_o); end
    total++; if (io.valid_o !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b want 0", io.valid_o); end
    total++; if (io.ready_o !== 1'b1) begin bad++; $display("FAIL mid_rst_ready: got %b want 1", io.ready_o); end
    tick();
    rst_n = 1'b1;
    tick();
    send(8'd100);
    wait_valid(k);
    total++; if (k != 8) begin bad++; $display("FAIL post_rst_latency: got %0d want 8", k); end
    total++; if (io.bcd_o !== 12'h100) begin bad++; $display("FAIL post_rst_bcd: got %h want 100", io.bcd_o); end
    io.ready_i = 1'b1; tick(); io.ready_i = 1'b0;
  endtask

  task automatic test_sweep();
    int k;
    logic [11:0] got;
    for (int v = 0; v < 256; v++) begin
      send(8'(v));
      wait_valid(k);
      got = io.bcd_o;
      total++; if (got !== dec_ref(v)) begin bad++; $display("FAIL sweep_bcd[%0d]: got %h want %h", v, got, dec_ref(v)); end
      total++; if (got[11:8] > 4'd9 || got[7:4] > 4'd9 || got[3:0] > 4'd9) begin
        bad++; $display("FAIL sweep_digit[%0d]: got %h want all digits <= 9", v, got);
      end
      repeat ($urandom_range(0, 3)) tick();
      total++; if (io.valid_o !== 1'b1) begin bad++; $display("FAIL sweep_stall[%0d]: got %b want 1", v, io.valid_o); end
      io.ready_i = 1'b1; tick(); io.ready_i = 1'b0;
      total++; if (io.valid_o !== 1'b0) begin bad++; $display("FAIL sweep_consume[%0d]: got %b want 0", v, io.valid_o); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bounds();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
